// File: rtl/simd_tag_fifo.sv
// simd_tag_fifo: show-ahead 3-bit tag FIFO; define SIMD_TAG_FIFO_BYPASS_EN for the empty-bypass path
module simd_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int AW = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          WR_EN,
    input  logic [2:0]    WR_DATA,
    output logic          FULL,
    input  logic          RD_EN,
    output logic [2:0]    RD_DATA,
    output logic          EMPTY,
    output logic [AW:0]   COUNT,
    output logic          OVF,
    output logic          UDF
);
    logic [2:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic ovf_q, udf_q, full_r, empty_r, push, pop, udf_set;
    assign full_r = cnt == (AW+1)'(DEPTH);
    assign empty_r = cnt == '0;
    assign pop = RD_EN & ~empty_r;
`ifdef SIMD_TAG_FIFO_BYPASS_EN
    assign push = WR_EN & ~full_r & ~(empty_r & RD_EN);
    assign udf_set = RD_EN & empty_r & ~WR_EN;
    assign EMPTY = empty_r & ~WR_EN;
    assign RD_DATA = empty_r ? (WR_EN ? WR_DATA : 3'b000) : mem[rp];
`else
    assign push = WR_EN & ~full_r;
    assign udf_set = RD_EN & empty_r;
    assign EMPTY = empty_r;
    assign RD_DATA = empty_r ? 3'b000 : mem[rp];
`endif
    assign FULL = full_r;
    assign COUNT = cnt;
    assign OVF = ovf_q;
    assign UDF = udf_q;
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 3'b000;
        end else begin
            if (push) begin
                mem[wp] <= WR_DATA;
                wp <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            if (WR_EN & full_r) ovf_q <= 1'b1;
            if (udf_set) udf_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_simd_tag_fifo.sv
// tb_simd_tag_fifo: directed self-checking bench for simd_tag_fifo
module tb_simd_tag_fifo;
    logic CLK, RESET, WR_EN, RD_EN, FULL, EMPTY, OVF, UDF;
    logic [2:0] WR_DATA, RD_DATA;
    logic [2:0] COUNT;
    int total = 0;
    int bad = 0;

    simd_tag_fifo #(.DEPTH(4), .AW(2)) dut (
        .CLK(CLK), .RESET(RESET), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .FULL(FULL),
        .RD_EN(RD_EN), .RD_DATA(RD_DATA), .EMPTY(EMPTY), .COUNT(COUNT), .OVF(OVF), .UDF(UDF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RESET = 1; WR_EN = 0; RD_EN = 0; WR_DATA = 0;
        tick();
        RESET = 0;
        #2;
        total++; if (EMPTY !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", EMPTY); end
        total++; if (FULL !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", FULL); end
        total++; if (COUNT !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", COUNT); end
        total++; if (RD_DATA !== 3'd0) begin bad++; $display("FAIL reset_rd_data got=%0d exp=0", RD_DATA); end
        total++; if ({OVF, UDF} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {OVF, UDF}); end
    endtask

    task automatic test_fill_drain;
        logic [2:0] v [4] = '{3'd5, 3'd2, 3'd7, 3'd1};
        for (int i = 0; i < 4; i++) begin
            WR_EN = 1; WR_DATA = v[i];
            #2;
            total++; if (FULL !== 1'b0) begin bad++; $display("FAIL fill_full_early[%0d] got=%0b exp=0", i, FULL); end
            tick();
        end
        WR_EN = 0;
        #2;
        total++; if (FULL !== 1'b1) begin bad++; $display("FAIL fill_full got=%0b exp=1", FULL); end
        total++; if (COUNT !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", COUNT); end
        for (int i = 0; i < 4; i++) begin
            RD_EN = 1;
            #2;
            total++; if (RD_DATA !== v[i]) begin bad++; $display("FAIL drain_data[%0d] got=%0d exp=%0d", i, RD_DATA, v[i]); end
            total++; if (FULL !== (i == 0)) begin bad++; $display("FAIL drain_full[%0d] got=%0b exp=%0b", i, FULL, i == 0); end
            tick();
        end
        RD_EN = 0;
        #2;
        total++; if (EMPTY !== 1'b1) begin bad++; $display("FAIL drain_empty got=%0b exp=1", EMPTY); end
        total++; if (RD_DATA !== 3'd0) begin bad++; $display("FAIL drain_rd_data got=%0d exp=0", RD_DATA); end
    endtask

    task automatic test_wrap;
        logic [2:0] pre [3] = '{3'd3, 3'd4, 3'd6};
        logic [2:0] exp [7] = '{3'd3, 3'd4, 3'd6, 3'd0, 3'd1, 3'd2, 3'd3};
        for (int i = 0; i < 3; i++) begin
            WR_EN = 1; WR_DATA = pre[i];
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            WR_EN = 1; RD_EN = 1; WR_DATA = 3'(i);
            #2;
            total++; if (RD_DATA !== exp[i]) begin bad++; $display("FAIL wrap_data[%0d] got=%0d exp=%0d", i, RD_DATA, exp[i]); end
            total++; if (COUNT !== 3'd3) begin bad++; $display("FAIL wrap_count[%0d] got=%0d exp=3", i, COUNT); end
            tick();
        end
        WR_EN = 0;
        for (int i = 4; i < 7; i++) begin
            RD_EN = 1;
            #2;
            total++; if (RD_DATA !== exp[i]) begin bad++; $display("FAIL wrap_data[%0d] got=%0d exp=%0d", i, RD_DATA, exp[i]); end
            tick();
        end
        RD_EN = 0;
        #2;
        total++; if (EMPTY !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%0b exp=1", EMPTY); end
    endtask

    task automatic test_errors;
        for (int i = 0; i < 4; i++) begin
            WR_EN = 1; WR_DATA = 3'(i + 1);
            tick();
        end
        WR_DATA = 3'd6;
        tick();
        WR_EN = 0;
        #2;
        total++; if (OVF !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b exp=1", OVF); end
        total++; if (UDF !== 1'b0) begin bad++; $display("FAIL ovf_udf got=%0b exp=0", UDF); end
        total++; if (COUNT !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", COUNT); end
        for (int i = 0; i < 4; i++) begin
            RD_EN = 1;
            #2;
            total++; if (RD_DATA !== 3'(i + 1)) begin bad++; $display("FAIL ovf_contents[%0d] got=%0d exp=%0d", i, RD_DATA, i + 1); end
            tick();
        end
        tick();
        RD_EN = 0;
        #2;
        total++; if (UDF !== 1'b1) begin bad++; $display("FAIL udf_set got=%0b exp=1", UDF); end
        total++; if (COUNT !== 3'd0) begin bad++; $display("FAIL udf_count got=%0d exp=0", COUNT); end
        tick(); tick(); tick();
        total++; if ({OVF, UDF} !== 2'b11) begin bad++; $display("FAIL flags_sticky got=%b exp=11", {OVF, UDF}); end
        RESET = 1;
        tick();
        RESET = 0;
        #2;
        total++; if ({OVF, UDF} !== 2'b00) begin bad++; $display("FAIL flags_cleared got=%b exp=00", {OVF, UDF}); end
    endtask

    task automatic test_reset_mid;
        WR_EN = 1; WR_DATA = 3'd7;
        tick();
        WR_DATA = 3'd2;
        tick();
        WR_DATA = 3'd3; RESET = 1;
        tick();
        RESET = 0; WR_EN = 0;
        #2;
        total++; if (COUNT !== 3'd0) begin bad++; $display("FAIL mid_reset_count got=%0d exp=0", COUNT); end
        total++; if (EMPTY !== 1'b1) begin bad++; $display("FAIL mid_reset_empty got=%0b exp=1", EMPTY); end
        WR_EN = 1; WR_DATA = 3'd5;
        tick();
        WR_EN = 0;
        #2;
        total++; if (RD_DATA !== 3'd5) begin bad++; $display("FAIL mid_reset_read got=%0d exp=5", RD_DATA); end
        total++; if (COUNT !== 3'd1) begin bad++; $display("FAIL mid_reset_count1 got=%0d exp=1", COUNT); end
        RD_EN = 1;
        tick();
        RD_EN = 0;
        #2;
        total++; if (EMPTY !== 1'b1) begin bad++; $display("FAIL mid_reset_drain got=%0b exp=1", EMPTY); end
    endtask

    task automatic test_bypass;
        WR_EN = 1; RD_EN = 1; WR_DATA = 3'd4;
        #2;
`ifdef SIMD_TAG_FIFO_BYPASS_EN
        total++; if (RD_DATA !== 3'd4) begin bad++; $display("FAIL byp_data got=%0d exp=4", RD_DATA); end
        total++; if (EMPTY !== 1'b0) begin bad++; $display("FAIL byp_empty got=%0b exp=0", EMPTY); end
        tick();
        WR_EN = 0; RD_EN = 0;
        #2;
        total++; if (COUNT !== 3'd0) begin bad++; $display("FAIL byp_count got=%0d exp=0", COUNT); end
        total++; if (UDF !== 1'b0) begin bad++; $display("FAIL byp_udf got=%0b exp=0", UDF); end
`else
        total++; if (RD_DATA !== 3'd0) begin bad++; $display("FAIL nobyp_data got=%0d exp=0", RD_DATA); end
        total++; if (EMPTY !== 1'b1) begin bad++; $display("FAIL nobyp_empty got=%0b exp=1", EMPTY); end
        tick();
        WR_EN = 0; RD_EN = 0;
        #2;
        total++; if (COUNT !== 3'd1) begin bad++; $display("FAIL nobyp_count got=%0d exp=1", COUNT); end
        total++; if (UDF !== 1'b1) begin bad++; $display("FAIL nobyp_udf got=%0b exp=1", UDF); end
        total++; if (RD_DATA !== 3'd4) begin bad++; $display("FAIL nobyp_stored got=%0d exp=4", RD_DATA); end
`endif
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_errors();
        test_reset_mid();
        test_bypass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/simd_tag_fifo.md
# simd_tag_fifo

Show-ahead FIFO for 3-bit SIMD lane/destination tags, sitting directly upstream of the 3-bit tag buffer stage in the SIMD DLX datapath. It absorbs bursts of tags from the decode stage and presents the oldest tag on a 3-bit output that drives the buffer stage. It reports full and empty flags and an occupancy count, and it latches sticky overflow and underflow error flags.

## Interface
- `DEPTH`, 4: number of entries. Must be a power of two and at least 2.
- `AW`, 2: pointer width. Must equal log2(DEPTH).

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `WR_EN` in 1: push request.
- `WR_DATA` in 3: tag to push.
- `FULL` out 1: high when COUNT == DEPTH.
- `RD_EN` in 1: pop request.
- `RD_DATA` out 3: oldest tag (show-ahead). Reads 3'b000 while EMPTY, except as described under Configuration.
- `EMPTY` out 1: high when COUNT == 0, except as described under Configuration.
- `COUNT` out AW+1: number of stored entries, 0..DEPTH.
- `OVF` out 1: sticky; set by a push attempted while FULL.
- `UDF` out 1: sticky; set by a pop attempted while EMPTY.

## Operation
- Storage: DEPTH×3 register array, write pointer `wp`, read pointer `rp`, and a registered count. Pointers are AW bits wide and wrap modulo DEPTH (3 → 0 for DEPTH=4).
- Push is accepted iff `WR_EN && !FULL`.
  - The array at `wp` is written and `wp` increments.
- Pop is accepted iff `RD_EN && !EMPTY`.
  - `rp` increments.
  - RD_DATA already showed the popped value during that cycle.
- Push and pop in the same cycle:
  - Neither full nor empty: both are accepted and COUNT is unchanged.
  - FULL: only the pop is accepted. COUNT becomes DEPTH-1 and OVF is set. Push-through while full is not supported.
  - EMPTY: only the push is accepted and UDF is set (non-bypass build).
- COUNT update: next = COUNT + push_acc − pop_acc.
- FULL and EMPTY are decoded from the registered COUNT. No combinational path from WR_EN/RD_EN to FULL or EMPTY (non-bypass build).
- RD_DATA = EMPTY ? 3'b000 : mem[rp].
- Rejected requests never modify the array, pointers, or COUNT.
- OVF and UDF, once set, stay high until RESET.
- Reset (synchronous, takes priority over any same-cycle WR_EN/RD_EN):
  - `wp`, `rp`, and COUNT go to 0.
  - All array entries go to 3'b000.
  - Outputs: EMPTY=1, FULL=0, OVF=0, UDF=0, RD_DATA=3'b000, COUNT=0.
  - Reset during a burst discards all stored tags. The first push after RESET deasserts lands at entry 0.

## Timing
- Write-to-read latency: a tag pushed at edge N appears on RD_DATA, with EMPTY low, after edge N (cycle N+1), when the FIFO was empty.
- Pop effect: after an accepted pop at edge N, RD_DATA shows the next entry in cycle N+1.
- Throughput: one push and one pop per cycle, sustained.
- FULL asserts in the cycle after the DEPTH-th accepted push. It deasserts in the cycle after the first accepted pop.
- OVF and UDF rise in the cycle after the offending request's edge.

## Configuration
- `SIMD_TAG_FIFO_BYPASS_EN` defined (empty-bypass path):
  - While COUNT==0 and WR_EN=1: RD_DATA = WR_DATA and EMPTY=0, combinationally.
  - If RD_EN is also 1 in that cycle: the tag passes straight through, nothing is stored, COUNT stays 0, and UDF is not set.
  - If RD_EN is 0: a normal push occurs.
  - Zero-cycle first-word latency.
- Not defined:
  - No bypass; behaviour is exactly as in Operation.
  - EMPTY and FULL are purely registered decodes.

## Test plan
- Reset then idle: after RESET=1 for 1 cycle → EMPTY=1, FULL=0, COUNT=0, RD_DATA=0, OVF=UDF=0.
- Fill and drain: push 5,2,7,1 on consecutive cycles → FULL=1, COUNT=4. Then pop 4 times → RD_DATA sequence 5,2,7,1, then EMPTY=1 and RD_DATA=0.
- Wrap and concurrency: push 3, 4, 6. Then push 0..3 while popping every cycle → output order 3,4,6,0,1,2,3, COUNT never exceeds 3, and the pointers wrap with no loss.
- Errors: with the FIFO full, assert WR_EN with WR_DATA=6 → contents unchanged and OVF=1 next cycle. Drain it, then assert RD_EN while EMPTY → UDF=1. Both flags stay high until RESET.
- Reset mid-operation: push 2 entries and assert RESET in the same cycle as a push → COUNT=0 and EMPTY=1 next cycle. A subsequent push of 5 then reads back 5.
- Bypass (macro defined): while empty, WR_EN=RD_EN=1 with WR_DATA=4 → RD_DATA=4 in the same cycle, COUNT stays 0, UDF=0. The same stimulus without the macro → RD_DATA=0 that cycle, UDF=1, and COUNT=1 next cycle.
